// File: rtl/msalu_pkg.sv
// Shared types for the msALU datapath: opcodes, ALU operation codes,
// T-state encoding and instruction field positions.
package msalu_pkg;

    typedef enum logic [3:0] {
        OP_LOAD = 4'b0000,
        OP_MOV  = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_INV  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_XOR  = 4'b0111
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_INV = 3'b010,
        ALU_AND = 3'b011,
        ALU_OR  = 3'b100,
        ALU_XOR = 3'b101
    } alu_op_t;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstate_t;

    localparam int OPC_HI = 9;
    localparam int OPC_LO = 6;
    localparam int RX_HI  = 5;
    localparam int RX_LO  = 4;
    localparam int RY_HI  = 3;
    localparam int RY_LO  = 2;

    function automatic logic is_alu_op(input opcode_t op);
        return (op inside {OP_ADD, OP_SUB, OP_INV, OP_AND, OP_OR, OP_XOR});
    endfunction

    function automatic alu_op_t alu_code(input opcode_t op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_INV:  return ALU_INV;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/msalu_dec2to4.sv
// 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
module msalu_dec2to4 (
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] y
);

    always_comb begin
        y = '0;
        if (en) y[sel] = 1'b1;
    end

endmodule

// File: rtl/msalu_ctrl.sv
// T-state control sequencer for the shared-bus msALU datapath.
// Optional illegal-opcode trap (Err port) enabled by MSALU_CTRL_ILLEGAL_TRAP_EN.
module msalu_ctrl
    import msalu_pkg::*;
#(
    parameter int NREG = 4,
    parameter int W    = 10
) (
    input  logic            CLKb,
    input  logic            Reset,
    input  logic            Run,
    input  logic [W-1:0]    INSTR,
    output logic [W-1:0]    IRout,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            ExternOut,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic [2:0]      ALUControl,
    output logic            Busy,
    output logic            Done
`ifdef MSALU_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic            Err
`endif
);

    tstate_t     state, nxt;
    logic [W-1:0] ir;
    opcode_t     op;
    logic [1:0]  rx, ry;
    logic        alu_op;
    logic        rin_en, rout_en;
    logic [1:0]  rin_sel, rout_sel;

    assign op     = opcode_t'(ir[OPC_HI:OPC_LO]);
    assign rx     = ir[RX_HI:RX_LO];
    assign ry     = ir[RY_HI:RY_LO];
    assign alu_op = is_alu_op(op);
    assign IRout  = ir;
    assign Busy   = (state != T0);

    always_ff @(posedge CLKb) begin
        if (Reset) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= nxt;
            if (state == T0 && Run) ir <= INSTR;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            T0:      if (Run) nxt = T1;
            T1:      nxt = alu_op ? T2 : T0;
            T2:      nxt = T3;
            default: nxt = T0;
        endcase
    end

    // Every bus driver comes from exactly one branch, so at most one is ever high.
    always_comb begin
        rin_en     = 1'b0;
        rin_sel    = rx;
        rout_en    = 1'b0;
        rout_sel   = rx;
        ExternOut  = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        Gout       = 1'b0;
        ALUControl = ALU_ADD;
        Done       = 1'b0;
        case (state)
            T1: begin
                if (op == OP_LOAD) begin
                    ExternOut = 1'b1;
                    rin_en    = 1'b1;
                    Done      = 1'b1;
                end else if (op == OP_MOV) begin
                    rout_en  = 1'b1;
                    rout_sel = ry;
                    rin_en   = 1'b1;
                    Done     = 1'b1;
                end else if (alu_op) begin
                    rout_en = 1'b1;
                    Ain     = 1'b1;
                end else begin
                    Done = 1'b1;
                end
            end
            T2: begin
                rout_en    = 1'b1;
                rout_sel   = ry;
                Gin        = 1'b1;
                ALUControl = alu_code(op);
            end
            T3: begin
                Gout   = 1'b1;
                rin_en = 1'b1;
                Done   = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MSALU_CTRL_ILLEGAL_TRAP_EN
    assign Err = (state == T1) && ir[OPC_HI];
`endif

    msalu_dec2to4 u_rin_dec (
        .en  (rin_en),
        .sel (rin_sel),
        .y   (Rin)
    );

    msalu_dec2to4 u_rout_dec (
        .en  (rout_en),
        .sel (rout_sel),
        .y   (Rout)
    );

endmodule

// File: tb/tb_msalu_ctrl.sv
// Self-checking bench for msalu_ctrl: directed table, hand sequences, random vs. schedule model.
module tb_msalu_ctrl;

    typedef struct packed {
        logic [3:0] rin;
        logic [3:0] rout;
        logic       ext;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [2:0] alu;
        logic       done;
        logic       err;
    } exp_t;

    typedef struct {
        logic [9:0] instr;
        int         n;
        exp_t       s0;
        exp_t       s1;
        exp_t       s2;
    } vec_t;

`ifdef MSALU_CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic       CLKb, Reset, Run;
    logic [9:0] INSTR, IRout;
    logic [3:0] Rin, Rout;
    logic       ExternOut, Ain, Gin, Gout, Busy, Done;
    logic [2:0] ALUControl;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic inv_on = 1'b0;

    msalu_ctrl #(.NREG(4), .W(10)) dut (
        .CLKb       (CLKb),
        .Reset      (Reset),
        .Run        (Run),
        .INSTR      (INSTR),
        .IRout      (IRout),
        .Rin        (Rin),
        .Rout       (Rout),
        .ExternOut  (ExternOut),
        .Ain        (Ain),
        .Gin        (Gin),
        .Gout       (Gout),
        .ALUControl (ALUControl),
        .Busy       (Busy),
        .Done       (Done)
`ifdef MSALU_CTRL_ILLEGAL_TRAP_EN
        ,
        .Err        (err)
`endif
    );

`ifndef MSALU_CTRL_ILLEGAL_TRAP_EN
    assign err = 1'b0;
`endif

    initial CLKb = 1'b0;
    always #5 CLKb = ~CLKb;

    function automatic exp_t mk(input logic [3:0] rin, input logic [3:0] rout, input logic ext,
                                input logic ain, input logic gin, input logic gout,
                                input logic [2:0] alu, input logic done, input logic e);
        exp_t x;
        x.rin = rin; x.rout = rout; x.ext = ext; x.ain = ain; x.gin = gin;
        x.gout = gout; x.alu = alu; x.done = done; x.err = e;
        return x;
    endfunction

    function automatic exp_t actual();
        return mk(Rin, Rout, ExternOut, Ain, Gin, Gout, ALUControl, Done, err);
    endfunction

    task automatic tick();
        @(posedge CLKb);
        #1;
    endtask

    task automatic chk_vec(input string name, input exp_t e);
        exp_t a;
        a = actual();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: outputs got %h expected %h", name, a, e);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1; Run = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    // Bus-driver and register-select invariants, every cycle once reset has been applied.
    always @(negedge CLKb) begin
        if (inv_on) begin
            checks++;
            if ($countones({ExternOut, Gout, Rout}) > 1 || $countones(Rin) > 1) begin
                errors++;
                $display("FAIL invariant: ext=%b gout=%b rout=%b rin=%b", ExternOut, Gout, Rout, Rin);
            end
        end
    end

    // Behavioural model: each accepted instruction becomes a list of per-cycle output records.
    exp_t       mq[$];
    logic [9:0] m_ir;

    task automatic model_push(input logic [9:0] instr);
        int op, rx, ry;
        logic [3:0] mrx, mry;
        op  = int'(instr[9:6]);
        rx  = int'(instr[5:4]);
        ry  = int'(instr[3:2]);
        mrx = 4'b0001 << rx;
        mry = 4'b0001 << ry;
        if (op == 0) begin
            mq.push_back(mk(mrx, 4'b0, 1, 0, 0, 0, 3'd0, 1, 0));
        end else if (op == 1) begin
            mq.push_back(mk(mrx, mry, 0, 0, 0, 0, 3'd0, 1, 0));
        end else if (op < 8) begin
            mq.push_back(mk(4'b0, mrx, 0, 1, 0, 0, 3'd0, 0, 0));
            mq.push_back(mk(4'b0, mry, 0, 0, 1, 0, 3'(op - 2), 0, 0));
            mq.push_back(mk(mrx, 4'b0, 0, 0, 0, 1, 3'd0, 1, 0));
        end else begin
            mq.push_back(mk(4'b0, 4'b0, 0, 0, 0, 0, 3'd0, 1, TRAP));
        end
    endtask

    vec_t vt[7];
    exp_t idle;

    initial begin
        int ndone;
        idle  = mk(4'b0, 4'b0, 0, 0, 0, 0, 3'd0, 0, 0);
        Reset = 1'b0; Run = 1'b0; INSTR = '0;

        vt[0] = '{10'b0000_10_00_00, 1, mk(4'b0100, 4'b0000, 1, 0, 0, 0, 3'b000, 1, 0), idle, idle};
        vt[1] = '{10'b0010_01_11_00, 3, mk(4'b0000, 4'b0010, 0, 1, 0, 0, 3'b000, 0, 0),
                  mk(4'b0000, 4'b1000, 0, 0, 1, 0, 3'b000, 0, 0),
                  mk(4'b0010, 4'b0000, 0, 0, 0, 1, 3'b000, 1, 0)};
        vt[2] = '{10'b0001_00_11_00, 1, mk(4'b0001, 4'b1000, 0, 0, 0, 0, 3'b000, 1, 0), idle, idle};
        vt[3] = '{10'b0011_10_10_00, 3, mk(4'b0000, 4'b0100, 0, 1, 0, 0, 3'b000, 0, 0),
                  mk(4'b0000, 4'b0100, 0, 0, 1, 0, 3'b001, 0, 0),
                  mk(4'b0100, 4'b0000, 0, 0, 0, 1, 3'b000, 1, 0)};
        vt[4] = '{10'b0100_11_01_00, 3, mk(4'b0000, 4'b1000, 0, 1, 0, 0, 3'b000, 0, 0),
                  mk(4'b0000, 4'b0010, 0, 0, 1, 0, 3'b010, 0, 0),
                  mk(4'b1000, 4'b0000, 0, 0, 0, 1, 3'b000, 1, 0)};
        vt[5] = '{10'b0111_00_01_11, 3, mk(4'b0000, 4'b0001, 0, 1, 0, 0, 3'b000, 0, 0),
                  mk(4'b0000, 4'b0010, 0, 0, 1, 0, 3'b101, 0, 0),
                  mk(4'b0001, 4'b0000, 0, 0, 0, 1, 3'b000, 1, 0)};
        vt[6] = '{10'b1010_00_00_00, 1, mk(4'b0000, 4'b0000, 0, 0, 0, 0, 3'b000, 1, TRAP), idle, idle};

        // Reset held two cycles with Run high.
        Reset = 1'b1; Run = 1'b1; INSTR = 10'b0010_01_11_00;
        tick(); tick();
        inv_on = 1'b1;
        chk_vec("reset_outputs", idle);
        chk_val("reset_busy", 32'(Busy), 0);
        chk_val("reset_ir", 32'(IRout), 0);
        Reset = 1'b0; INSTR = 10'b0000_10_00_00;
        tick();
        Run = 1'b0;
        chk_vec("release_samples_run", vt[0].s0);
        tick();
        chk_vec("release_then_idle", idle);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            Run = 1'b1; INSTR = vt[i].instr;
            tick();
            Run = 1'b0; INSTR = '0;
            chk_val($sformatf("vec%0d_ir", i), 32'(IRout), 32'(vt[i].instr));
            for (int k = 0; k < vt[i].n; k++) begin
                chk_vec($sformatf("vec%0d_step%0d", i, k), (k == 0) ? vt[i].s0 : (k == 1) ? vt[i].s1 : vt[i].s2);
                chk_val($sformatf("vec%0d_busy%0d", i, k), 32'(Busy), 1);
                tick();
            end
            chk_vec($sformatf("vec%0d_idle", i), idle);
            chk_val($sformatf("vec%0d_idle_busy", i), 32'(Busy), 0);
        end

        // Back-to-back: XOR then MOV with Run held high.
        do_reset();
        Run = 1'b1; INSTR = 10'b0111_01_10_00;
        tick();
        INSTR = 10'b0001_11_01_00;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (Done) ndone++;
            if (c == 1) chk_val("b2b_xor_alu", 32'(ALUControl), 32'b101);
            if (c == 3) chk_val("b2b_gap_busy", 32'(Busy), 0);
            if (c == 4) begin
                chk_val("b2b_mov_ir", 32'(IRout), 32'(10'b0001_11_01_00));
                chk_vec("b2b_mov_step", mk(4'b1000, 4'b0010, 0, 0, 0, 0, 3'b000, 1, 0));
            end
            tick();
        end
        chk_val("b2b_done_count", 32'(ndone), 2);

        // Reset during T2 of SUB aborts it.
        do_reset();
        Run = 1'b1; INSTR = 10'b0011_01_10_00;
        tick();
        Run = 1'b0;
        tick();
        chk_val("abort_in_t2", 32'(Gin), 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_vec($sformatf("abort_quiet%0d", c), idle);
            chk_val($sformatf("abort_busy%0d", c), 32'(Busy), 0);
            tick();
        end

        // Run toggled while busy is ignored.
        Run = 1'b1; INSTR = 10'b0010_01_11_00;
        tick();
        INSTR = 10'b0000_10_00_00;
        tick();
        chk_val("busy_ir_held", 32'(IRout), 32'(10'b0010_01_11_00));
        chk_val("busy_still_alu", 32'(Gin), 1);
        Run = 1'b0;
        tick();
        chk_val("busy_done_t3", 32'(Done & Gout), 1);
        tick();
        chk_val("busy_back_idle", 32'(Busy), 0);
        tick();
        chk_vec("busy_no_extra", idle);

        // Randomized run against the schedule model.
        do_reset();
        mq.delete();
        m_ir = '0;
        for (int c = 0; c < 800; c++) begin
            chk_vec("rand_out", (mq.size() > 0) ? mq[0] : idle);
            chk_val("rand_busy", 32'(Busy), 32'(mq.size() > 0));
            chk_val("rand_ir", 32'(IRout), 32'(m_ir));
            Reset = ($urandom_range(0, 39) == 0);
            Run   = $urandom_range(0, 2) != 0;
            INSTR = 10'($urandom);
            if (Reset) begin
                mq.delete();
                m_ir = '0;
            end else if (mq.size() > 0) begin
                void'(mq.pop_front());
            end else if (Run) begin
                m_ir = INSTR;
                model_push(INSTR);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/msalu_ctrl.md
# msalu_ctrl

- Control sequencer that drives the shared 10-bit bus datapath around `msALU`.
- Latches a 10-bit instruction when `Run` is asserted, then steps a T-state machine that generates every datapath enable: register file in/out selects, `Ain`, `Gin`, `Gout`, `ALUControl` and the external-data bus driver.
- It is the initiator to the ALU's responder. It guarantees at most one bus driver per cycle and signals completion with a one-cycle `Done` pulse.

## Interface
Parameters:
- `NREG`, 4, number of general registers R0..R3; the register-select fields are log2(NREG) = 2 bits.
- `W`, 10, instruction and bus width.

Ports:
- `CLKb`  in  1  clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Run`  in  1  start request, sampled only in T0.
- `INSTR`  in  W  instruction, valid while `Run`=1 in T0.
- `IRout`  out  W  latched instruction, for debug.
- `Rin`  out  NREG  one-hot register load enables.
- `Rout`  out  NREG  one-hot register bus-drive enables.
- `ExternOut`  out  1  external data drives the bus.
- `Ain`, `Gin`, `Gout`  out  1 each  ALU register A load, G load, G bus-drive.
- `ALUControl`  out  3  ALU operation select.
- `Busy`  out  1  state ≠ T0.
- `Done`  out  1  one-cycle completion pulse.
- `Err`  out  1  illegal-opcode pulse; present only with the macro below.

## Operation
Instruction format:
- `[9:6]` opcode.
- `[5:4]` Rx, destination and first operand.
- `[3:2]` Ry, second operand.
- `[1:0]` reserved, ignored.

Opcodes:
- 0000 LOAD: Rx ← external data.
- 0001 MOV: Rx ← Ry.
- 0010 ADD, 0011 SUB, 0100 INV, 0101 AND, 0110 OR, 0111 XOR: Rx ← Rx op Ry.
- INV produces 0 − Ry; Rx is ignored by the ALU but the sequence is still uniform.
- 1000–1111: illegal.

ALUControl mapping:
- ADD 000, SUB 001, INV 010, AND 011, OR 100, XOR 101.
- Outside T2, `ALUControl` = 000.

States T0, T1, T2, T3 are held in a 2-bit counter. All outputs are Moore-style, decoded from state and IR only.

- **T0 (idle):** when `Run`=1, IR ← INSTR and go to T1; otherwise stay. No enables asserted.
- **T1, LOAD:** `ExternOut`, `Rin[Rx]`, `Done`; next T0.
- **T1, MOV:** `Rout[Ry]`, `Rin[Rx]`, `Done`; next T0.
- **T1, ALU ops:** `Rout[Rx]`, `Ain`; next T2.
- **T2 (ALU ops only):** `Rout[Ry]`, `Gin`, `ALUControl` = mapped code; next T3.
- **T3 (ALU ops only):** `Gout`, `Rin[Rx]`, `Done`; next T0.
- **Illegal opcode:** handled per Configuration.
- **Rx = Ry:** legal. MOV is a no-op write; SUB yields 0.

Invariants:
- At most one of `ExternOut`, `Gout`, `Rout[*]` is high in any cycle.
- `Rin` and `Rout` are each zero or one-hot.

## Timing
- **Reset:** synchronous; dominates `Run` and every state.
  - Next edge: state T0, IR = 0.
  - All outputs 0, including `Done`, `Busy` and `Err`.
  - Reset mid-instruction aborts it: no further enables, no `Done`.
- **Run handshake:** `Run` is ignored while `Busy`=1. Holding `Run` high gives back-to-back instructions, with a single T0 cycle between them.
- **Latency, Run-sampling edge to `Done`-high cycle:**
  - LOAD and MOV: 1 cycle.
  - ALU ops: 3 cycles.
- **Throughput, one instruction per:**
  - LOAD and MOV: 2 cycles.
  - ALU ops: 4 cycles.
- **Done pulse:** `Done` is high exactly in the final T-state and is never high in T0.
- **Register file and ALU capture:** on the same `CLKb` edge that ends the asserting state.
  - A captures in T1.
  - G captures in T2.
  - Rx captures in the final state.

## Configuration
Macro: `MSALU_CTRL_ILLEGAL_TRAP_EN`.

- **Defined:** an illegal opcode in T1 asserts `Err` and `Done` for that one cycle with no datapath enables, then returns to T0.
- **Undefined:** the `Err` port is absent. An illegal opcode executes as a NOP: T1 with `Done` only, then T0.

## Structure
Shared package `msalu_pkg` holds:
- opcode enum;
- `alu_op_t` with the ALUControl codes above;
- state enum T0–T3;
- instruction field position constants.

`msALU` imports the same `alu_op_t`.

Sub-module `msalu_dec2to4` is the 2-to-4 one-hot decoder with enable, instantiated twice: once for `Rin`, once for `Rout`.

## Test plan
- **Reset:** `Reset`=1 for 2 cycles with `Run`=1 → all outputs 0, `Busy`=0; first edge after release samples `Run`.
- **LOAD:** `INSTR`=10'b0000_10_00_00, `Run`=1 → next cycle `ExternOut`=1, `Rin`=0100, `Done`=1; following cycle idle.
- **ADD:** `INSTR`=10'b0010_01_11_00 →
  - T1: `Rout`=0010, `Ain`=1.
  - T2: `Rout`=1000, `Gin`=1, `ALUControl`=000.
  - T3: `Gout`=1, `Rin`=0010, `Done`=1.
- **Back-to-back:** `Run` held high with XOR then MOV → XOR `ALUControl`=101 in T2; MOV latched in the T0 after XOR's `Done`; exactly 2 `Done` pulses over 6 cycles.
- **Abort and busy:** `Reset` asserted during T2 of SUB → no `Gout`/`Rin`/`Done` afterwards. Separately, `Run` toggled while busy → ignored.
- **Illegal opcode:** `INSTR`=10'b1010_00_00_00 → with macro, `Err`=`Done`=1 for one cycle, no enables; without macro, `Done` only. In every test, the bus-driver one-hot invariant is asserted each cycle.
